// File: rtl/i2s_rx.sv
// I2S receiver: brings an external SCK/WS/SD stream into the i_clk domain, assembles
// left/right words and queues complete stereo pairs in a small FIFO.
module i2s_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic                            i_clr,
    input  logic                            i_sck,
    input  logic                            i_ws,
    input  logic                            i_sd,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [DATA_WIDTH-1:0]           o_left,
    output logic [DATA_WIDTH-1:0]           o_right,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
    output logic                            o_overrun,
    output logic                            o_frame_err,
    output logic [1:0]                      o_state
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} state_t;

    logic [2:0]              sync_q [SYNC_STAGES];
    logic                    sck_s, ws_s, sd_s;
    logic                    sck_prev_q, evt_q, ws_evt_q, sd_evt_q, ws_last_q;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0]   sr_q, sr_d, sr_shift, left_q, left_d;
    logic                    hold_q, hold_d, push, err_set, full, ws_chg;
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q;
    logic                    overrun_q, frame_err_q, pop, push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {i_sck, i_ws, i_sd};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {sck_s, ws_s, sd_s} = sync_q[SYNC_STAGES-1];

    // Handshake: a pair transfers on every cycle with o_valid && i_ready; the head holds until then.
    assign pop     = o_valid && i_ready;
    assign push_ok = push && ((level_q < LW'(FIFO_DEPTH)) || pop);

    assign full     = (cnt_q == CW'(DATA_WIDTH));
    assign sr_shift = full ? sr_q : {sr_q[DATA_WIDTH-2:0], sd_evt_q};
    assign cnt_inc  = full ? cnt_q : cnt_q + CW'(1);
    assign ws_chg   = (ws_evt_q != ws_last_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        left_d  = left_q;
        hold_d  = hold_q;
        push    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE:  if (i_enable) state_d = SYNC;
            SYNC:  if (evt_q && ws_last_q && !ws_evt_q) begin
                       state_d = LEFT;
                       cnt_d   = '0;
                   end
            default: if (evt_q) begin
                // The bit sampled with a WS change still belongs to the old word.
                sr_d  = sr_shift;
                cnt_d = cnt_inc;
                if (ws_chg) begin
                    cnt_d   = '0;
                    state_d = ws_evt_q ? RIGHT : LEFT;
                    if (cnt_inc != CW'(DATA_WIDTH)) begin
                        err_set = 1'b1;
                        if (state_q == LEFT) hold_d = 1'b0;
                    end else if (state_q == LEFT) begin
                        left_d = sr_shift;
                        hold_d = 1'b1;
                    end else if (hold_q) begin
                        push   = 1'b1;
                        hold_d = 1'b0;
                    end
                end
            end
        endcase
        if (!i_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            hold_d  = 1'b0;
            push    = 1'b0;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_prev_q  <= 1'b0;
            evt_q       <= 1'b0;
            ws_evt_q    <= 1'b0;
            sd_evt_q    <= 1'b0;
            ws_last_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            left_q      <= '0;
            hold_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            evt_q      <= sck_s & ~sck_prev_q;
            ws_evt_q   <= ws_s;
            sd_evt_q   <= sd_s;
            if (evt_q) ws_last_q <= ws_evt_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            left_q  <= left_d;
            hold_q  <= hold_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {left_q, sr_d};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            level_q <= level_q + LW'(push_ok) - LW'(pop);
            if (push && !push_ok) overrun_q <= 1'b1;
            else if (i_clr)       overrun_q <= 1'b0;
            if (err_set)          frame_err_q <= 1'b1;
            else if (i_clr)       frame_err_q <= 1'b0;
        end
    end

    assign o_valid     = (level_q != '0);
    assign o_left      = mem_q[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH];
    assign o_right     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign o_level     = level_q;
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;
    assign o_state     = state_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Directed sequence with random word data for i2s_rx; expected pairs and flags come
// from a queue-based model of what a well-formed I2S stream should deliver.
module tb_i2s_rx;
    localparam int DW = 32, DEPTH = 2, SS = 2, HP = 12;
    localparam int LW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst, en, clr, sck, ws, sd, ready;
    logic valid, ovr, ferr;
    logic [DW-1:0] left, right;
    logic [LW-1:0] level;
    logic [1:0] state;

    int n_cmp = 0, n_err = 0, lat;
    logic [2*DW-1:0] exp_q[$];
    logic exp_ovr, exp_ferr;
    logic [DW-1:0] pl[3], pr[3], wa, wb;

    always #5 clk = ~clk;

    i2s_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clr(clr),
        .i_sck(sck), .i_ws(ws), .i_sd(sd),
        .o_valid(valid), .i_ready(ready), .o_left(left), .o_right(right),
        .o_level(level), .o_overrun(ovr), .o_frame_err(ferr), .o_state(state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " level"}, 64'(level), 64'(exp_q.size()));
        chk({tag, " valid"}, 64'(valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk({tag, " head"}, {left, right}, exp_q[0]);
        chk({tag, " overrun"}, 64'(ovr), 64'(exp_ovr));
        chk({tag, " frame_err"}, 64'(ferr), 64'(exp_ferr));
    endtask

    // A complete pair lands in the FIFO unless it is full, in which case it is lost.
    task automatic model_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
        else exp_ovr = 1'b1;
    endtask

    task automatic slot(input logic w, input logic d, input bit measure);
        sck = 1'b0; ws = w; sd = d;
        repeat (HP) @(negedge clk);
        sck = 1'b1;
        for (int k = 1; k <= HP; k++) begin
            @(posedge clk); #1;
            if (measure && lat < 0 && valid) lat = k;
            @(negedge clk);
        end
    endtask

    task automatic word_slot(input logic w_now, input logic w_next, input logic [DW-1:0] data,
                             input int nbits, input int total, input int j, input bit measure);
        logic bit_d, ws_d;
        if (j < nbits) bit_d = data[DW-1-j];
        else bit_d = 1'($urandom_range(0, 1));
        ws_d = (j == total - 1) ? w_next : w_now;
        slot(ws_d, bit_d, measure);
    endtask

    task automatic send_word(input logic w_now, input logic w_next, input logic [DW-1:0] data,
                             input int nbits, input int total, input bit measure);
        for (int j = 0; j < total; j++)
            word_slot(w_now, w_next, data, nbits, total, j, measure && (j == total - 1));
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input int total,
                             input bit measure);
        send_word(1'b0, 1'b1, l, DW, total, 1'b0);
        send_word(1'b1, 1'b0, r, DW, total, measure);
    endtask

    task automatic pop_pair(input string tag);
        if (exp_q.size() != 0) begin
            chk({tag, " pop head"}, {left, right}, exp_q[0]);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            void'(exp_q.pop_front());
            check_all({tag, " after pop"});
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: bench exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b0;
        exp_ovr = 1'b0; exp_ferr = 1'b0; lat = -1;
        repeat (3) @(negedge clk);
        chk("reset state", 64'(state), 64'(0));
        check_all("reset");
        chk("reset left", 64'(left), 64'(0));
        chk("reset right", 64'(right), 64'(0));

        // Basic pair with latency measurement on the completing SCK edge.
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        chk("enable to sync", 64'(state), 64'(1));
        send_word(1'b1, 1'b0, $urandom, DW, 4, 1'b0);
        lat = -1;
        send_pair(32'hA5A5_0F0F, 32'h1234_5678, 32, 1'b1);
        model_pair(32'hA5A5_0F0F, 32'h1234_5678);
        chk("valid latency", 64'(lat), 64'(SS + 2));
        check_all("basic");
        pop_pair("basic");

        // Three pairs into a two-deep FIFO with the consumer stalled.
        for (int p = 0; p < 3; p++) begin
            pl[p] = $urandom; pr[p] = $urandom;
            send_pair(pl[p], pr[p], 32, 1'b0);
            model_pair(pl[p], pr[p]);
            check_all($sformatf("fill%0d", p));
        end
        pop_pair("ovr pop1");
        pop_pair("ovr pop2");
        pulse_clr();
        check_all("clr overrun");

        // Short left word: flagged, its right partner dropped silently.
        wa = $urandom;
        send_word(1'b0, 1'b1, wa, 20, 20, 1'b0);
        send_word(1'b1, 1'b0, $urandom, DW, 32, 1'b0);
        exp_ferr = 1'b1;
        check_all("frame err");
        wa = $urandom; wb = $urandom;
        send_pair(wa, wb, 32, 1'b0);
        model_pair(wa, wb);
        check_all("after frame err");
        pop_pair("after frame err");
        pulse_clr();
        check_all("clr frame_err");

        // 64 SCK per channel: only the first DW bits after each WS change count.
        for (int p = 0; p < 2; p++) begin
            pl[p] = $urandom; pr[p] = $urandom;
            send_pair(pl[p], pr[p], 64, 1'b0);
            model_pair(pl[p], pr[p]);
        end
        check_all("long frame");
        pop_pair("long frame");

        // Disable keeps the FIFO; re-enable mid right word skips that partial frame.
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("disabled state", 64'(state), 64'(0));
        check_all("disabled");
        send_word(1'b0, 1'b1, $urandom, DW, 32, 1'b0);
        wa = $urandom;
        for (int j = 0; j < 32; j++) begin
            if (j == 10) en = 1'b1;
            word_slot(1'b1, 1'b0, wa, DW, 32, j, 1'b0);
        end
        wa = $urandom; wb = $urandom;
        send_pair(wa, wb, 32, 1'b0);
        model_pair(wa, wb);
        check_all("mid enable");
        pop_pair("mid enable a");
        pop_pair("mid enable b");

        // Reset in the middle of a right word with one entry queued.
        wa = $urandom; wb = $urandom;
        send_pair(wa, wb, 32, 1'b0);
        model_pair(wa, wb);
        check_all("pre reset");
        send_word(1'b0, 1'b1, $urandom, DW, 32, 1'b0);
        wb = $urandom;
        for (int j = 0; j < 10; j++) word_slot(1'b1, 1'b0, wb, DW, 32, j, 1'b0);
        rst = 1'b1;
        #1;
        exp_q.delete(); exp_ovr = 1'b0; exp_ferr = 1'b0;
        check_all("in reset");
        chk("in reset left", 64'(left), 64'(0));
        chk("in reset right", 64'(right), 64'(0));
        chk("in reset state", 64'(state), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int j = 10; j < 32; j++) word_slot(1'b1, 1'b0, wb, DW, 32, j, 1'b0);
        wa = $urandom; wb = $urandom;
        send_pair(wa, wb, 32, 1'b0);
        model_pair(wa, wb);
        check_all("post reset");
        pop_pair("post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
